// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared definitions for the move-generation pipeline: piece and colour codes,
// move-slot geometry, the {x,y} square-index helper and the move_collector
// FSM state type.
// -----------------------------------------------------------------------------
package chess_pkg;

    localparam int unsigned NSQ      = 64;            // square units, index {x[2:0], y[2:0]}
    localparam int unsigned SLOTW    = 6;             // bits per move slot
    localparam int unsigned SLOTS    = 8;             // move slots per FIFO word
    localparam int unsigned WORDW    = SLOTS * SLOTW; // FIFO word width
    localparam int unsigned MAXMOVES = 255;           // move-count saturation limit
    localparam int unsigned CNTW     = 8;             // move-count width

    localparam logic [CNTW-1:0] MAX_COUNT = CNTW'(MAXMOVES);

    typedef enum logic [2:0] {
        EMPTY,
        PAWN,
        KNIGHT,
        BISHOP,
        ROOK,
        QUEEN,
        KING
    } piece_t;

    typedef enum logic {
        WHITE,
        BLACK
    } color_t;

    typedef logic [SLOTW-1:0] sq_t;

    function automatic sq_t sq_index(input logic [2:0] x, input logic [2:0] y);
        return {x, y};
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_FETCH,
        ST_CAPT,
        ST_EMIT,
        ST_FIN
    } mc_state_t;

endpackage

// File: rtl/move_collector_if.sv
// -----------------------------------------------------------------------------
// move_collector_if
// Bundles the square-FIFO read bus and the move-stream handshake.
//   sq_done/sq_empty : per-square status flags (array -> collector)
//   sq_rden/sq_sel   : one-hot FIFO read enable and selected index
//   sq_data          : FIFO read data, valid one cycle after sq_rden
//   mv_valid/mv_ready/mv_from/mv_to : move stream to the search stage
// master = collector side, slave = square array / consumer side.
// -----------------------------------------------------------------------------
interface move_collector_if;
    import chess_pkg::*;

    logic [NSQ-1:0]   sq_done;
    logic [NSQ-1:0]   sq_empty;
    logic [NSQ-1:0]   sq_rden;
    logic [WORDW-1:0] sq_data;
    sq_t              sq_sel;
    logic             mv_valid;
    logic             mv_ready;
    sq_t              mv_from;
    sq_t              mv_to;

    modport master (
        input  sq_done, sq_empty, sq_data, mv_ready,
        output sq_rden, sq_sel, mv_valid, mv_from, mv_to
    );

    modport slave (
        output sq_done, sq_empty, sq_data, mv_ready,
        input  sq_rden, sq_sel, mv_valid, mv_from, mv_to
    );

endinterface

// File: rtl/move_collector_word_unpacker.sv
// -----------------------------------------------------------------------------
// word_unpacker
// Holds one captured FIFO word and walks its 8 slots MSB-first, streaming each
// non-empty slot as a (from,to) move through a registered valid/ready stage.
// A slot equal to the current square is an empty slot and is skipped.
//   i_load      : capture i_word and restart at slot 0
//   i_sel       : current square (destination and empty-slot marker)
//   i_ready     : consumer ready
//   o_valid/o_from/o_to : registered move output
//   o_word_done : last slot handled and output stage drained this cycle
// -----------------------------------------------------------------------------
module word_unpacker
    import chess_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WORDW-1:0] i_word,
    input  sq_t              i_sel,
    input  logic             i_ready,
    output logic             o_valid,
    output sq_t              o_from,
    output sq_t              o_to,
    output logic             o_word_done
);

    logic [WORDW-1:0] r_word;
    logic [3:0]       r_slot;     // 0..8; bit 3 set = all slots consumed
    logic             r_active;
    logic             r_valid;
    sq_t              r_from;
    sq_t              r_to;

    sq_t  w_slots [SLOTS];
    sq_t  w_cur;
    logic w_free;
    logic w_more;
    logic w_skip;

    always_comb begin
        for (int unsigned k = 0; k < SLOTS; k++) begin
            w_slots[k] = r_word[WORDW-1-SLOTW*k -: SLOTW];
        end
        w_cur       = w_slots[r_slot[2:0]];
        // Output register can take a new value when empty or being accepted.
        w_free      = !r_valid || i_ready;
        w_more      = r_active && !r_slot[3];
        w_skip      = (w_cur == i_sel);
        o_word_done = r_active && r_slot[3] && w_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word   <= '0;
            r_slot   <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
            r_from   <= '0;
            r_to     <= '0;
        end else if (i_load) begin
            r_word   <= i_word;
            r_slot   <= '0;
            r_active <= 1'b1;
        end else if (w_more && w_free) begin
            r_slot  <= r_slot + 4'd1;
            r_valid <= !w_skip;
            if (!w_skip) begin
                r_from <= w_cur;
                r_to   <= i_sel;
            end
        end else if (w_free) begin
            r_valid <= 1'b0;
            if (r_slot[3]) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_from  = r_from;
    assign o_to    = r_to;

endmodule

// File: rtl/move_collector.sv
// -----------------------------------------------------------------------------
// move_collector
// Waits for all 64 square units to report done (two consecutive all-ones
// cycles), then scans the square FIFOs in index order, drains each word and
// streams the unpacked moves out one per handshake. Counts emitted moves with
// saturation and a sticky overflow flag.
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle pulse, honoured only in IDLE
//   bus         : square FIFO bus and move stream (master modport)
//   list_done   : one-cycle pulse when the scan completes
//   move_count  : moves emitted this board, saturating at MAXMOVES
//   overflow    : sticky, a move was emitted with the count already saturated
// -----------------------------------------------------------------------------
module move_collector
    import chess_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    move_collector_if.master bus,
    output logic            list_done,
    output logic [CNTW-1:0] move_count,
    output logic            overflow
);

    mc_state_t       r_state;
    sq_t             r_sel;
    logic [NSQ-1:0]  r_rden;
    logic            r_done_seen;
    logic            r_list_done;
    logic [CNTW-1:0] r_count;
    logic            r_overflow;

    logic w_load;
    logic w_mv_valid;
    sq_t  w_mv_from;
    sq_t  w_mv_to;
    logic w_word_done;
    logic w_accept;

    assign w_load   = (r_state == ST_CAPT);
    assign w_accept = w_mv_valid && bus.mv_ready;

    word_unpacker u_unpacker (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_word      (bus.sq_data),
        .i_sel       (r_sel),
        .i_ready     (bus.mv_ready),
        .o_valid     (w_mv_valid),
        .o_from      (w_mv_from),
        .o_to        (w_mv_to),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_rden      <= '0;
            r_done_seen <= 1'b0;
            r_list_done <= 1'b0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rden      <= '0;
            r_list_done <= 1'b0;

            if (w_accept) begin
                if (r_count == MAX_COUNT) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_sel       <= '0;
                        r_done_seen <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                // Two consecutive all-ones samples mask the single-cycle
                // done dropout produced by the squares' hold logic.
                ST_WAIT: begin
                    if (&bus.sq_done) begin
                        if (r_done_seen) begin
                            r_state <= ST_CHECK;
                        end
                        r_done_seen <= 1'b1;
                    end else begin
                        r_done_seen <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (!bus.sq_empty[r_sel]) begin
                        r_rden  <= {{(NSQ-1){1'b0}}, 1'b1} << r_sel;
                        r_state <= ST_FETCH;
                    end else if (r_sel == sq_t'(NSQ-1)) begin
                        // Raised on entry so the pulse coincides with FIN.
                        r_list_done <= 1'b1;
                        r_state     <= ST_FIN;
                    end else begin
                        r_sel <= r_sel + 6'd1;
                    end
                end
                ST_FETCH: r_state <= ST_CAPT;
                ST_CAPT:  r_state <= ST_EMIT;
                ST_EMIT: begin
                    // Revisit the same square: its FIFO may hold more words.
                    if (w_word_done) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_FIN:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sq_rden  = r_rden;
    assign bus.sq_sel   = r_sel;
    assign bus.mv_valid = w_mv_valid;
    assign bus.mv_from  = w_mv_from;
    assign bus.mv_to    = w_mv_to;
    assign list_done    = r_list_done;
    assign move_count   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_move_collector.sv
// -----------------------------------------------------------------------------
// tb_move_collector
// Bench for move_collector: behavioural square FIFOs, a move scoreboard fed
// when words are loaded, a table of single-word boards and hand-written
// multi-cycle sequences (two words, stall, overflow, reset, done dropout).
// -----------------------------------------------------------------------------
module tb_move_collector;
    import chess_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       list_done;
    logic [7:0] move_count;
    logic       overflow;

    move_collector_if bus();

    move_collector dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .list_done  (list_done),
        .move_count (move_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- square FIFO model ----------------
    localparam int DEPTH = 40;
    logic [WORDW-1:0] mem [NSQ][DEPTH];
    int unsigned fcnt [NSQ] = '{default: 0};
    int unsigned frd  [NSQ] = '{default: 0};
    logic flush = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < NSQ; i++) begin
            if (flush) begin
                frd[i] <= fcnt[i];
            end else if (bus.sq_rden[i] && frd[i] < DEPTH) begin
                bus.sq_data <= mem[i][frd[i]];
                frd[i]      <= frd[i] + 1;
            end
        end
    end

    always_comb begin
        bus.sq_empty = '0;
        for (int i = 0; i < NSQ; i++) begin
            bus.sq_empty[i] = (frd[i] == fcnt[i]);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
    } mv_t;
    mv_t exp_q[$];

    task automatic load_word(input int sq, input logic [WORDW-1:0] w);
        logic [5:0] s;
        mem[sq][fcnt[sq]] = w;
        fcnt[sq] = fcnt[sq] + 1;
        for (int k = 0; k < 8; k++) begin
            s = w[47-6*k -: 6];
            if (s != 6'(sq)) exp_q.push_back('{from: s, to: 6'(sq)});
        end
    endtask

    function automatic logic [47:0] mkword(input logic [5:0] a, b, c, d, e, f, g, h);
        return {a, b, c, d, e, f, g, h};
    endfunction

    // ---------------- monitor + ready driver ----------------
    int   accepted    = 0;
    int   rden_cnt    = 0;
    int   ldone_cnt   = 0;
    int   stall_hits  = 0;
    int   stall_at    = -1;
    int   stall_left  = 0;
    int   sel13_moves = 0;
    logic sel13_seen  = 1'b1;
    logic prev_valid  = 1'b0;
    logic prev_ready  = 1'b1;
    logic [5:0] prev_from, prev_to;

    initial begin
        mv_t e;
        bus.mv_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid   = 1'b0;
                bus.mv_ready = 1'b1;
            end else begin
                if (stall_at >= 0 && accepted == stall_at) begin
                    stall_left = 5;
                    stall_at   = -1;
                end
                if (stall_left > 0) begin
                    bus.mv_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.mv_ready = 1'b1;
                end

                if (prev_valid && !prev_ready) begin
                    stall_hits++;
                    check("hold_valid", bus.mv_valid, 1);
                    check("hold_from", bus.mv_from, prev_from);
                    check("hold_to", bus.mv_to, prev_to);
                end

                if (bus.sq_rden != '0) begin
                    rden_cnt++;
                    check("rden_onehot", $countones(bus.sq_rden), 1);
                    check("rden_matches_sel", bus.sq_rden[bus.sq_sel], 1);
                    check("rden_nonempty", bus.sq_empty[bus.sq_sel], 0);
                end

                if (bus.mv_valid && bus.mv_ready) begin
                    accepted++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_move", {bus.mv_from, bus.mv_to}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("mv_from", bus.mv_from, e.from);
                        check("mv_to", bus.mv_to, e.to);
                    end
                end

                if (list_done) ldone_cnt++;

                if (!sel13_seen && bus.sq_sel == 6'd13) begin
                    sel13_seen  = 1'b1;
                    sel13_moves = accepted;
                end

                prev_valid = bus.mv_valid;
                prev_ready = bus.mv_ready;
                prev_from  = bus.mv_from;
                prev_to    = bus.mv_to;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts a board and counts cycles until list_done; drop_cyc inserts a
    // one-cycle sq_done dropout, restart_cyc pulses start mid-scan.
    task automatic run_board(input int drop_cyc, input int restart_cyc, output int lat);
        lat = -1;
        bus.sq_done = (drop_cyc > 0) ? '0 : '1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            bus.sq_done = (c == drop_cyc) ? '0 : '1;
            start = (c == restart_cyc);
            if (list_done) begin
                lat = c;
                break;
            end
            step();
        end
        start = 1'b0;
        if (lat < 0) check("list_done_timeout", 0, 1);
        step();
        check("list_done_one_cycle", list_done, 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        int          sq;
        logic        has;
        logic [47:0] word;
        int          exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, r0, a0, l0;
        logic [5:0] sq12;

        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, a0, l0, s0;
        logic [5:0] sq12;

        sq12 = sq_index(3'd1, 3'd4);
        vecs[0] = '{sq: 0,  has: 1'b0, word: '0, exp_cnt: 0, exp_lat: 67};
        vecs[1] = '{sq: 12, has: 1'b1, word: mkword(6'h0B, 6'h04, 6'h14, 6'h0C, 6'h0C, 6'h0C, 6'h0C, 6'h0C), exp_cnt: 3, exp_lat: -1};
        vecs[2] = '{sq: 0,  has: 1'b1, word: mkword(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8), exp_cnt: 8, exp_lat: -1};
        vecs[3] = '{sq: 63, has: 1'b1, word: {8{6'd63}}, exp_cnt: 0, exp_lat: -1};
        vecs[4] = '{sq: 63, has: 1'b1, word: mkword(6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7), exp_cnt: 8, exp_lat: -1};
        vecs[5] = '{sq: 5,  has: 1'b1, word: mkword(6'd5, 6'd9, 6'd5, 6'd9, 6'd5, 6'd9, 6'd5, 6'd9), exp_cnt: 4, exp_lat: -1};

        reset = 1'b1;
        start = 1'b0;
        bus.sq_done = '0;
        repeat (3) step();
        check("rst_list_done", list_done, 0);
        check("rst_move_count", move_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mv_valid", bus.mv_valid, 0);
        check("rst_sq_rden", bus.sq_rden, 0);
        check("rst_sq_sel", bus.sq_sel, 0);
        reset = 1'b0;
        step();

        // 260 moves: 32 full words plus one word with 4 moves on square 20.
        for (int w = 0; w < 32; w++) load_word(20, mkword(6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37));
        load_word(20, mkword(6'd30, 6'd31, 6'd32, 6'd33, 6'd20, 6'd20, 6'd20, 6'd20));
        a0 = accepted;
        r0 = rden_cnt;
        run_board(0, 0, lat);
        check("ovf_move_count", move_count, 255);
        check("ovf_flag", overflow, 1);
        check("ovf_moves_emitted", accepted - a0, 260);
        check("ovf_rden_pulses", rden_cnt - r0, 33);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].has) load_word(vecs[v].sq, vecs[v].word);
            r0 = rden_cnt;
            l0 = ldone_cnt;
            run_board(0, (v == 0) ? 40 : 0, lat);
            check("tbl_move_count", move_count, vecs[v].exp_cnt);
            check("tbl_overflow_cleared", overflow, 0);
            check("tbl_rden_pulses", rden_cnt - r0, vecs[v].has ? 1 : 0);
            check("tbl_list_done_pulses", ldone_cnt - l0, 1);
            if (vecs[v].exp_lat >= 0) check("tbl_scan_latency", lat, vecs[v].exp_lat);
        end

        // Two words on square 12: both bursts complete before sq_sel reaches 13.
        load_word(sq12, vecs[1].word);
        load_word(sq12, mkword(6'h0D, 6'h0E, 6'h0C, 6'h0C, 6'h0C, 6'h0C, 6'h0C, 6'h0C));
        r0 = rden_cnt;
        a0 = accepted;
        sel13_seen = 1'b0;
        run_board(0, 0, lat);
        check("two_word_rden_pulses", rden_cnt - r0, 2);
        check("two_word_moves_before_sel13", sel13_moves - a0, 5);
        check("two_word_move_count", move_count, 5);

        // mv_ready low for 5 cycles after the second move of a burst.
        load_word(40, vecs[2].word);
        s0 = stall_hits;
        stall_at = accepted + 2;
        run_board(0, 0, lat);
        check("stall_cycles_held", stall_hits - s0, 5);
        check("stall_move_count", move_count, 8);

        // Reset while a move is being offered.
        load_word(sq12, vecs[1].word);
        l0 = ldone_cnt;
        bus.sq_done = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            if (bus.mv_valid) begin
                lat = c;
                break;
            end
            step();
        end
        if (lat < 0) check("emit_wait_timeout", 0, 1);
        reset = 1'b1;
        step();
        check("rst_emit_mv_valid", bus.mv_valid, 0);
        check("rst_emit_list_done", list_done, 0);
        check("rst_emit_sq_sel", bus.sq_sel, 0);
        reset = 1'b0;
        exp_q.delete();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (100) step();
        check("rst_emit_no_list_done", ldone_cnt - l0, 0);
        check("rst_emit_idle_count", move_count, 0);

        // One-cycle sq_done dropout delays the scan by two cycles.
        run_board(2, 0, lat);
        check("dropout_scan_latency", lat, 69);
        check("dropout_move_count", move_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
